// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words,
// writes them through the external port, then releases the CPU.
module imem_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [63:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] CAP  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [ADDR_W:0]   n_cnt;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       word, word_nx;
  logic [ADDR_W:0]   n_eff;
  logic              load;
  logic              accept;

  assign ren_ext = 1'b0;
  assign n_eff   = (num_words > CAP) ? CAP : num_words;

  // Next-state logic; also builds the word including the byte accepted this cycle.
  always_comb begin
    state_nx = state;
    word_nx  = word;
    load     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (n_eff == ZERO) ? RUN : COLLECT;
        end else begin
          state_nx = state;
        end
      end
      COLLECT: begin
        if (byte_valid) begin
          accept = 1'b1;
          word_nx[{byte_idx, 3'b000} +: 8] = byte_data;
          state_nx = (byte_idx == 2'd3) ? WRITE : COLLECT;
        end else begin
          state_nx = COLLECT;
        end
      end
      WRITE: begin
        state_nx = ((word_idx + ONE) == n_cnt) ? RUN : COLLECT;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counters and outputs; outputs are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      n_cnt      <= ZERO;
      word_idx   <= ZERO;
      byte_idx   <= 2'd0;
      word       <= 32'd0;
      byte_ready <= 1'b0;
      wen_ext    <= 1'b0;
      addr_ext   <= 64'd0;
      wdata_ext  <= 32'd0;
      busy       <= 1'b0;
      cpu_enable <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        n_cnt    <= n_eff;
        word_idx <= ZERO;
        byte_idx <= 2'd0;
      end else if (accept) begin
        word     <= word_nx;
        byte_idx <= byte_idx + 2'd1;
      end else if (state == WRITE) begin
        word_idx <= word_idx + ONE;
      end
      byte_ready <= (state_nx == COLLECT);
      wen_ext    <= (state_nx == WRITE);
      busy       <= (state_nx == COLLECT) || (state_nx == WRITE);
      cpu_enable <= (state_nx == RUN);
      done       <= (state_nx == RUN);
      // word_idx still names the word being written; it advances on leaving WRITE.
      if (state_nx == WRITE) begin
        addr_ext  <= {{(61-ADDR_W){1'b0}}, word_idx, 2'b00};
        wdata_ext <= word_nx;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (ADDR_W=9 and ADDR_W=2) share stimulus
// and are checked every cycle against a transaction-level model of the load protocol.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [9:0]  nw;
  logic        bv;
  logic [7:0]  bd;

  wire [1:0]        br, we, re, ce, bz, dn;
  wire [1:0][63:0]  ad;
  wire [1:0][31:0]  wd;

  int n_chk = 0;
  int n_fail = 0;

  // model state per instance: 0 = ADDR_W 9, 1 = ADDR_W 2
  bit          m_loading [2];
  bit          m_running [2];
  bit          m_pend    [2];
  int          m_cnt     [2];
  int          m_n       [2];
  int          m_wr      [2];
  logic [31:0] m_buf     [2];
  logic [63:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic [63:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [7:0]  bq [$];

  imem_loader #(.ADDR_W(9)) u_big (
    .clk(clk), .arst(arst), .start(start), .num_words(nw),
    .byte_valid(bv), .byte_data(bd), .byte_ready(br[0]), .addr_ext(ad[0]),
    .wen_ext(we[0]), .ren_ext(re[0]), .wdata_ext(wd[0]), .cpu_enable(ce[0]),
    .busy(bz[0]), .done(dn[0])
  );

  imem_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .arst(arst), .start(start), .num_words(nw[2:0]),
    .byte_valid(bv), .byte_data(bd), .byte_ready(br[1]), .addr_ext(ad[1]),
    .wen_ext(we[1]), .ren_ext(re[1]), .wdata_ext(wd[1]), .cpu_enable(ce[1]),
    .busy(bz[1]), .done(dn[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_loading[i] = 1'b0; m_running[i] = 1'b0; m_pend[i] = 1'b0;
      m_cnt[i] = 0; m_n[i] = 0;
      m_buf[i] = 32'd0; m_addr[i] = 64'd0; m_wdata[i] = 32'd0;
    end
  endtask

  // Protocol model: a load is "count bytes until N*4 received", each fourth byte
  // schedules one write cycle that blocks further bytes.
  task automatic model_step();
    if (arst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nwv;
        int cap;
        int n;
        if (m_pend[i]) begin
          m_pend[i] = 1'b0;
          if (m_cnt[i] / 4 == m_n[i]) begin
            m_loading[i] = 1'b0;
            m_running[i] = 1'b1;
          end
        end else if (m_loading[i]) begin
          if (bv) begin
            m_buf[i][8*(m_cnt[i]%4) +: 8] = bd;
            m_cnt[i]++;
            if (m_cnt[i] % 4 == 0) begin
              m_pend[i]  = 1'b1;
              m_addr[i]  = 64'(4 * (m_cnt[i] / 4 - 1));
              m_wdata[i] = m_buf[i];
              m_wr[i]++;
              if (i == 0) begin
                log_addr.push_back(m_addr[i]);
                log_data.push_back(m_wdata[i]);
              end
            end
          end
        end else if (start) begin
          nwv = (i == 0) ? int'(nw) : int'(nw[2:0]);
          cap = (i == 0) ? 512 : 4;
          n   = (nwv > cap) ? cap : nwv;
          m_n[i]   = n;
          m_cnt[i] = 0;
          if (n == 0) begin
            m_running[i] = 1'b1;
          end else begin
            m_running[i] = 1'b0;
            m_loading[i] = 1'b1;
          end
        end
      end
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("byte_ready[%0d]", i), 64'(br[i]), 64'(m_loading[i] && !m_pend[i]));
      chk($sformatf("wen_ext[%0d]", i),    64'(we[i]), 64'(m_pend[i]));
      chk($sformatf("ren_ext[%0d]", i),    64'(re[i]), 64'd0);
      chk($sformatf("busy[%0d]", i),       64'(bz[i]), 64'(m_loading[i]));
      chk($sformatf("cpu_enable[%0d]", i), 64'(ce[i]), 64'(m_running[i]));
      chk($sformatf("done[%0d]", i),       64'(dn[i]), 64'(m_running[i]));
      chk($sformatf("addr_ext[%0d]", i),   ad[i],      m_addr[i]);
      chk($sformatf("wdata_ext[%0d]", i),  64'(wd[i]), 64'(m_wdata[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_start(input logic [9:0] n);
    start = 1'b1;
    nw    = n;
    tick();
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random stalls
  task automatic send_bytes(input int nbytes, input int mode, input bit allow_start);
    int k = 0;
    int budget = nbytes * 8 + 50;
    bit ph = 1'b1;
    bit acc;
    while (k < nbytes && budget > 0) begin
      case (mode)
        0:       bv = 1'b1;
        1:       begin bv = ph; ph = ~ph; end
        default: bv = ($urandom_range(3) != 0);
      endcase
      bd = bv ? bq[k] : 8'($urandom);
      if (allow_start && $urandom_range(7) == 0) begin
        start = 1'b1;
        nw    = 10'($urandom_range(1, 6));
      end
      acc = bv && m_loading[0] && !m_pend[0];
      tick();
      start = 1'b0;
      if (acc) k++;
      budget--;
    end
    bv = 1'b0;
    if (k < nbytes) chk("send_timeout", 64'(k), 64'(nbytes));
  endtask

  task automatic wait_run(input int i);
    int budget = 20;
    while (!m_running[i] && budget > 0) begin
      tick();
      budget--;
    end
    if (!m_running[i]) chk("wait_run_timeout", 64'd0, 64'd1);
  endtask

  task automatic fill_random(input int nbytes);
    bq.delete();
    for (int j = 0; j < nbytes; j++) bq.push_back(8'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_zero"}, {ad[i], 7'd0, br[i]} == 71'd0 && wd[i] == 32'd0 &&
          we[i] == 1'b0 && bz[i] == 1'b0 && ce[i] == 1'b0 && dn[i] == 1'b0 ? 64'd1 : 64'd0, 64'd1);
    end
  endtask

  initial begin
    int base;
    int wr0;
    int wr1;
    arst = 1'b1; start = 1'b0; nw = 10'd0; bv = 1'b0; bd = 8'd0;
    model_reset();
    m_wr[0] = 0; m_wr[1] = 0;
    repeat (3) tick();
    check_all_zero("reset");
    arst = 1'b0;
    repeat (2) tick();

    // two-word program, bytes back-to-back
    base = log_addr.size();
    bq = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    pulse_start(10'd2);
    send_bytes(8, 0, 1'b0);
    wait_run(0);
    chk("s1_nwrites", 64'(log_addr.size() - base), 64'd2);
    if (log_addr.size() - base == 2) begin
      chk("s1_addr0", log_addr[base],   64'h0);
      chk("s1_data0", 64'(log_data[base]),   64'h00500013);
      chk("s1_addr1", log_addr[base+1], 64'h4);
      chk("s1_data1", 64'(log_data[base+1]), 64'h00100093);
    end
    chk("s1_cpu_en", 64'(ce[0]), 64'd1);

    // one word with valid toggling; then valid keeps toggling while running
    arst = 1'b1; model_reset(); tick(); arst = 1'b0; tick();
    base = log_addr.size();
    bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pulse_start(10'd1);
    send_bytes(4, 1, 1'b0);
    wait_run(0);
    for (int j = 0; j < 6; j++) begin bv = ~bv; bd = 8'($urandom); tick(); end
    bv = 1'b0;
    chk("s2_nwrites", 64'(log_addr.size() - base), 64'd1);
    chk("s2_data", 64'(log_data[log_data.size()-1]), 64'hDEADBEEF);
    chk("s2_addr", log_addr[log_addr.size()-1], 64'h0);

    // zero-word load from IDLE
    arst = 1'b1; model_reset(); tick(); arst = 1'b0; tick();
    wr0 = m_wr[0];
    pulse_start(10'd0);
    tick();
    chk("s3_cpu_en", 64'(ce[0]), 64'd1);
    chk("s3_nowrite", 64'(m_wr[0] - wr0), 64'd0);

    // asynchronous reset after two bytes of word 1 in a 3-word load
    fill_random(6);
    pulse_start(10'd3);
    send_bytes(6, 0, 1'b0);
    base = log_addr.size();
    arst = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_rst");
    tick();
    arst = 1'b0;
    for (int j = 0; j < 5; j++) begin bv = 1'($urandom); bd = 8'($urandom); tick(); end
    bv = 1'b0;
    chk("s4_no_write", 64'(log_addr.size() - base), 64'd0);
    fill_random(4);
    pulse_start(10'd1);
    send_bytes(4, 2, 1'b0);
    wait_run(0);
    chk("s4_reload_addr", log_addr[log_addr.size()-1], 64'h0);

    // small instance saturates at 4 words
    wr0 = m_wr[0]; wr1 = m_wr[1];
    fill_random(28);
    pulse_start(10'd7);
    send_bytes(28, 2, 1'b0);
    wait_run(0);
    wait_run(1);
    chk("s5_small_writes", 64'(m_wr[1] - wr1), 64'd4);
    chk("s5_big_writes",   64'(m_wr[0] - wr0), 64'd7);

    // restart from RUN
    fill_random(8);
    pulse_start(10'd2);
    chk("s6_cpu_en_off", 64'(ce[0]), 64'd0);
    chk("s6_busy", 64'(bz[0]), 64'd1);
    base = log_addr.size();
    send_bytes(8, 2, 1'b0);
    wait_run(0);
    chk("s6_first_addr", log_addr[base], 64'h0);

    // full-capacity load on the big instance, request larger than capacity
    wr0 = m_wr[0];
    fill_random(2048);
    pulse_start(10'h3FF);
    send_bytes(2048, 0, 1'b0);
    wait_run(0);
    chk("s7_writes", 64'(m_wr[0] - wr0), 64'd512);
    chk("s7_last_addr", log_addr[log_addr.size()-1], 64'h7FC);

    // random loads with ignored start pulses mid-load
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(4 * n);
      pulse_start(10'(n));
      send_bytes(4 * n, 2, 1'b1);
      wait_run(0);
      repeat (3) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 SHALL have ports:
  - clk  in  1  main clock, all state on rising edge.
  - arst  in  1  reset, asynchronous, active-high.
  - start  in  1  single-cycle load request.
  - num_words  in  ADDR_W+1  words to load, sampled when start is accepted.
  - byte_valid  in  1  byte_data is valid.
  - byte_data  in  8  program byte stream, little-endian within each word.
  - byte_ready  out  1  loader accepts a byte this cycle.
  - addr_ext  out  64  byte address to instruction memory external port.
  - wen_ext  out  1  instruction memory external write enable.
  - ren_ext  out  1  instruction memory external read enable; constant 0.
  - wdata_ext  out  32  word written to instruction memory.
  - cpu_enable  out  1  drives cpu enable.
  - busy  out  1  load in progress.
  - done  out  1  load complete, cpu running.
REQ-003 Reset SHALL be asynchronous and active-high on arst; single clock clk.

Function
REQ-004 SHALL implement FSM with states IDLE, COLLECT, WRITE, RUN.
REQ-005 Byte transfer SHALL occur only on a cycle where byte_valid=1 and byte_ready=1.
REQ-006 byte_ready SHALL be 1 only in COLLECT; it SHALL NOT depend combinationally on byte_valid.
REQ-007 IDLE: start=1 SHALL latch effective count N=min(num_words, 2^ADDR_W), clear word index and byte index.
  - If N=0, go to RUN.
  - Otherwise, go to COLLECT.
REQ-008 COLLECT: k-th accepted byte of a word (k=0..3) SHALL be placed in word bits [8k+7:8k].
  - After byte 3 is accepted, go to WRITE next cycle.
REQ-009 WRITE SHALL last exactly one cycle with wen_ext=1.
  - addr_ext = word_index*4, zero-extended to 64 bits.
  - wdata_ext = assembled word.
REQ-010 On leaving WRITE, word index SHALL increment.
  - If the written word was index N-1, go to RUN.
  - Otherwise, go to COLLECT.
REQ-011 Latency: wen_ext SHALL assert in the cycle immediately after the 4th byte of a word is accepted.
REQ-012 wen_ext SHALL be 0 in all states except WRITE.
  - addr_ext and wdata_ext SHALL hold their last values when wen_ext=0.
REQ-013 busy SHALL be 1 in COLLECT and WRITE, else 0.
REQ-014 RUN: cpu_enable=1 and done=1; all other states: cpu_enable=0 and done=0.
REQ-015 start=1 while in RUN SHALL restart a load, same as REQ-007.
  - cpu_enable SHALL be 0 from the next cycle.
REQ-016 start SHALL be ignored in COLLECT and WRITE.
REQ-017 byte_valid SHALL be ignored outside COLLECT; no byte is consumed.
REQ-018 Word index SHALL be ADDR_W+1 bits wide.
  - When N=2^ADDR_W, the last written address SHALL be (2^ADDR_W-1)*4.
  - The index SHALL NOT wrap before completion.
REQ-019 A stalled stream (byte_valid=0 in COLLECT) SHALL hold all state indefinitely; there is no timeout.

Reset
REQ-020 arst=1 SHALL immediately force:
  - state IDLE
  - word index and byte index 0
  - assembled word 0
  - addr_ext 0, wdata_ext 0
  - wen_ext 0, byte_ready 0, busy 0, done 0, cpu_enable 0
REQ-021 arst asserted mid-load SHALL abandon the partial word with no write.
  - After release, the loader SHALL wait in IDLE for a new start.

Verification
REQ-022 Scenario: start with num_words=2; bytes 13,00,50,00,93,00,10,00 sent back-to-back.
  - Required: wen_ext pulses at addr 0 with 0x00500013, then at addr 4 with 0x00100093.
  - Required: cpu_enable=1 on the cycle after the second write.
REQ-023 Scenario: byte_valid toggled 1/0 every cycle during a 1-word load of 0xDEADBEEF.
  - Required: exactly one write, addr 0, data 0xDEADBEEF.
  - Required: byte_ready never asserted outside COLLECT.
REQ-024 Scenario: start with num_words=0.
  - Required: no write; cpu_enable=1 two cycles after start.
REQ-025 Scenario: arst pulsed after 2 bytes of word 1 during a 3-word load.
  - Required: all outputs 0 asynchronously; no write to addr 4; the next start reloads from addr 0.
REQ-026 Scenario: ADDR_W=2, num_words=7.
  - Required: exactly 4 writes at addrs 0,4,8,12, then RUN.
REQ-027 Scenario: start pulsed in RUN.
  - Required: cpu_enable=0 next cycle, busy=1, reload begins at addr 0.
